// File: rtl/descriptor_fetcher.sv
// descriptor_fetcher: Avalon-MM master walking linked 4-word DMA descriptors.
// Optional write-back of status/len is enabled by defining DESC_FETCH_WRITEBACK_EN.
module descriptor_fetcher #(
    parameter int ADDR_WIDTH = 9,
    parameter int MAX_CHAIN  = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] head_ptr,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [3:0]            mem_byteenable,
    output logic [31:0]           mem_writedata,
    output logic                  mem_clken,
    input  logic [31:0]           mem_readdata,
    output logic                  desc_valid,
    input  logic                  desc_ready,
    output logic [31:0]           desc_src,
    output logic [31:0]           desc_dst,
    output logic [15:0]           desc_len,
    output logic [6:0]            desc_ctrl,
    input  logic                  cmpl_valid,
    input  logic [7:0]            cmpl_status,
    input  logic [15:0]           cmpl_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CHECK,
        S_PRESENT,
        S_WAIT,
        S_WB,
        S_NEXT
    } state_t;

    localparam logic [16:0] CHAIN_MAX = 17'(MAX_CHAIN);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(3));

    state_t                  state;
    state_t                  state_n;
    logic [ADDR_WIDTH-1:0]   base;
    logic [2:0]              rd_cnt;
    logic [16:0]             chain_cnt;
    logic [31:0]             w0;
    logic [31:0]             w1;
    logic [31:0]             w2;
    logic [ADDR_WIDTH-1:0]   w3;
    logic                    done_q;
    logic                    err_q;
    logic                    done_n;
    logic                    err_n;
    logic                    load_head;
    logic                    load_next;
    logic                    chain_inc;
    logic                    unused_bits;

`ifdef DESC_FETCH_WRITEBACK_EN
    logic [7:0]              st_q;
    logic [15:0]             ln_q;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode and control strobes
    always_comb begin
        state_n   = state;
        done_n    = 1'b0;
        err_n     = 1'b0;
        load_head = 1'b0;
        load_next = 1'b0;
        chain_inc = 1'b0;
        unique case (state)
            S_IDLE: begin
                // busy is still high while done/err pulses, so start waits
                if (start && !done_q && !err_q) begin
                    load_head = 1'b1;
                    state_n   = S_RD;
                end
            end
            S_RD: begin
                if (abort) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else if (rd_cnt == 3'd4) begin
                    state_n = S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort || !w2[31]) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else if (chain_cnt == CHAIN_MAX) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    chain_inc = 1'b1;
                    state_n   = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (abort) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else if (desc_ready) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else if (cmpl_valid) begin
`ifdef DESC_FETCH_WRITEBACK_EN
                    state_n = S_WB;
`else
                    state_n = S_NEXT;
`endif
                end
            end
            S_WB: begin
                // the write itself happens this cycle regardless of abort
                if (abort) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    state_n = S_NEXT;
                end
            end
            S_NEXT: begin
                if (abort) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    load_next = 1'b1;
                    state_n   = S_RD;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Memory bus drive: reads in RD address cycles, one write in WB
    always_comb begin
        mem_address    = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = '0;
        if (state == S_RD && rd_cnt != 3'd4) begin
            mem_chipselect = 1'b1;
            mem_address    = base + ADDR_WIDTH'(rd_cnt);
        end
`ifdef DESC_FETCH_WRITEBACK_EN
        if (state == S_WB) begin
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
            mem_address    = base + ADDR_WIDTH'(2);
            mem_writedata  = {1'b0, w2[30:24], st_q, ln_q};
        end
`endif
    end

    // Descriptor pointer, read sequencing, word capture and chain count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base      <= '0;
            rd_cnt    <= '0;
            chain_cnt <= '0;
            w0        <= '0;
            w1        <= '0;
            w2        <= '0;
            w3        <= '0;
        end else begin
            if (load_head) begin
                base      <= head_ptr & ALIGN_MASK;
                chain_cnt <= '0;
            end
            if (load_next) begin
                base <= w3 & ALIGN_MASK;
            end
            if (chain_inc) begin
                chain_cnt <= chain_cnt + 17'd1;
            end
            if (state == S_RD) begin
                rd_cnt <= rd_cnt + 3'd1;
                // data for address k arrives while rd_cnt == k+1
                case (rd_cnt)
                    3'd1:    w0 <= mem_readdata;
                    3'd2:    w1 <= mem_readdata;
                    3'd3:    w2 <= mem_readdata;
                    3'd4:    w3 <= mem_readdata[ADDR_WIDTH-1:0];
                    default: ;
                endcase
            end else begin
                rd_cnt <= '0;
            end
        end
    end

`ifdef DESC_FETCH_WRITEBACK_EN
    // Completion capture for the write-back word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q <= '0;
            ln_q <= '0;
        end else if (state == S_WAIT && cmpl_valid && !abort) begin
            st_q <= cmpl_status;
            ln_q <= cmpl_len;
        end
    end
`endif

    // Registered end-of-chain pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= done_n;
            err_q  <= err_n;
        end
    end

`ifdef DESC_FETCH_WRITEBACK_EN
    assign unused_bits = ^{w2[23:16], mem_readdata[31:ADDR_WIDTH]};
`else
    assign unused_bits = ^{w2[23:16], mem_readdata[31:ADDR_WIDTH],
                           cmpl_status, cmpl_len};
`endif

    assign desc_valid     = (state == S_PRESENT) && !abort;
    assign desc_src       = w0;
    assign desc_dst       = w1;
    assign desc_len       = w2[15:0];
    assign desc_ctrl      = w2[30:24];
    assign busy           = (state != S_IDLE) || done_q || err_q;
    assign done           = done_q;
    assign err            = err_q;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_descriptor_fetcher.sv
// tb_descriptor_fetcher: scoreboard bench with a behavioural descriptor memory.
// Expectations follow DESC_FETCH_WRITEBACK_EN when it is defined.
module tb_descriptor_fetcher;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [8:0]  head_ptr;
    logic        abort;
    logic [8:0]  mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic [31:0] mem_readdata;
    logic        desc_valid;
    logic        desc_ready;
    logic [31:0] desc_src;
    logic [31:0] desc_dst;
    logic [15:0] desc_len;
    logic [6:0]  desc_ctrl;
    logic        cmpl_valid;
    logic [7:0]  cmpl_status;
    logic [15:0] cmpl_len;
    logic        busy;
    logic        done;
    logic        err;

`ifdef DESC_FETCH_WRITEBACK_EN
    localparam int CMPL_LAT = 8;
    localparam int N_T4     = 1;
    localparam int T4_KIND  = 1;
`else
    localparam int CMPL_LAT = 7;
    localparam int N_T4     = 3;
    localparam int T4_KIND  = 2;
`endif

    descriptor_fetcher #(
        .ADDR_WIDTH (9),
        .MAX_CHAIN  (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .head_ptr       (head_ptr),
        .abort          (abort),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .desc_valid     (desc_valid),
        .desc_ready     (desc_ready),
        .desc_src       (desc_src),
        .desc_dst       (desc_dst),
        .desc_len       (desc_len),
        .desc_ctrl      (desc_ctrl),
        .cmpl_valid     (cmpl_valid),
        .cmpl_status    (cmpl_status),
        .cmpl_len       (cmpl_len),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [512];
    logic [31:0] rdata;
    logic [86:0] mon_exp;
    logic [8:0]  rd_q [$];
    logic [86:0] sb_q [$];
    int          checks = 0;
    int          errors = 0;
    int          hs_cnt = 0;
    int          wr_cnt = 0;

    assign mem_readdata = rdata;

    // Behavioural memory: one-cycle read latency, no waitrequest
    always @(posedge clk) begin
        if (mem_chipselect && mem_write) mem[mem_address] = mem_writedata;
        if (mem_chipselect && !mem_write) rdata <= mem[mem_address];
    end

    task automatic chk(input string tag, input logic [159:0] got,
                       input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Bus/handshake monitor and scoreboard pop
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_chipselect && !mem_write) rd_q.push_back(mem_address);
            if (mem_chipselect && mem_write) wr_cnt++;
            if (desc_valid && desc_ready) begin
                hs_cnt++;
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    mon_exp = sb_q.pop_front();
                    chk("desc", {desc_src, desc_dst, desc_len, desc_ctrl},
                        mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_desc(input logic [8:0] b, input logic [31:0] src,
                            input logic [31:0] dst, input logic own,
                            input logic [6:0] ctrl, input logic [15:0] len,
                            input logic [8:0] nxt, input logic push);
        mem[b]         = src;
        mem[9'(b + 1)] = dst;
        mem[9'(b + 2)] = {own, ctrl, 8'h00, len};
        mem[9'(b + 3)] = {23'd0, nxt};
        if (push) sb_q.push_back({src, dst, len, ctrl});
    endtask

    task automatic check_reset(input string tag);
        chk(tag,
            {mem_address, mem_chipselect, mem_write, mem_byteenable,
             mem_writedata, mem_clken, desc_valid, desc_src, desc_dst,
             desc_len, desc_ctrl, busy, done, err},
            {9'd0, 1'b0, 1'b0, 4'hF, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0,
             16'd0, 7'd0, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic start_chain(input logic [8:0] h);
        head_ptr = h;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!desc_valid && lat < 60) begin
            tick();
            lat++;
        end
        if (!desc_valid) chk("valid_timeout", desc_valid, 1);
    endtask

    task automatic accept();
        desc_ready = 1'b1;
        tick();
        desc_ready = 1'b0;
    endtask

    task automatic complete(input logic [7:0] st, input logic [15:0] ln);
        cmpl_valid  = 1'b1;
        cmpl_status = st;
        cmpl_len    = ln;
        tick();
        cmpl_valid  = 1'b0;
    endtask

    task automatic wait_end(output int kind);
        kind = 0;
        for (int i = 0; i < 80; i++) begin
            if (done) begin
                kind = 1;
                break;
            end
            if (err) begin
                kind = 2;
                break;
            end
            tick();
        end
        if (kind == 0) chk("end_timeout", kind, 1);
    endtask

    task automatic check_reads(input string tag, input logic [8:0] e[8]);
        chk({tag, "_count"}, rd_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_%0d", tag, i),
                (i < rd_q.size()) ? {1'b0, rd_q[i]} : 10'h3FF,
                {1'b0, e[i]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          kind;
        int          h0;
        int          w0;
        logic [8:0]  ea [8];
        logic [31:0] t1_exp;

        reset       = 1'b1;
        start       = 1'b0;
        head_ptr    = '0;
        abort       = 1'b0;
        desc_ready  = 1'b0;
        cmpl_valid  = 1'b0;
        cmpl_status = '0;
        cmpl_len    = '0;
        rdata       = '0;
        for (int i = 0; i < 512; i++) mem[i] = '0;
        #1;
        check_reset("reset_outs");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        // single descriptor, then terminator with OWN=0
        set_desc(9'h010, 32'h1000_0000, 32'h2000_0000, 1'b1, 7'h2A,
                 16'h0040, 9'h020, 1'b1);
        set_desc(9'h020, 32'h0, 32'h0, 1'b0, 7'h00, 16'h0, 9'h000, 1'b0);
        rd_q.delete();
        start_chain(9'h010);
        chk("t1_busy", busy, 1);
        wait_valid(lat);
        chk("t1_latency", lat, 6);
        accept();
        tick();
        complete(8'h01, 16'h0040);
        wait_end(kind);
        chk("t1_end", kind, 1);
        chk("t1_busy_at_done", busy, 1);
        tick();
        chk("t1_after_done", {done, busy}, 2'b00);
`ifdef DESC_FETCH_WRITEBACK_EN
        t1_exp = {1'b0, 7'h2A, 8'h01, 16'h0040};
`else
        t1_exp = {1'b1, 7'h2A, 8'h00, 16'h0040};
`endif
        chk("t1_word2", mem[9'h012], t1_exp);
        ea = '{9'h010, 9'h011, 9'h012, 9'h013,
               9'h020, 9'h021, 9'h022, 9'h023};
        check_reads("t1_rd", ea);

        // address wrap at the top of memory
        set_desc(9'h1FC, 32'hAAAA_0001, 32'hBBBB_0002, 1'b1, 7'h11,
                 16'h0100, 9'h000, 1'b1);
        set_desc(9'h000, 32'h0, 32'h0, 1'b0, 7'h00, 16'h0, 9'h000, 1'b0);
        rd_q.delete();
        start_chain(9'h1FD);
        wait_valid(lat);
        chk("t2_latency", lat, 6);
        accept();
        complete(8'h00, 16'h0100);
        wait_end(kind);
        chk("t2_end", kind, 1);
        tick();
        ea = '{9'h1FC, 9'h1FD, 9'h1FE, 9'h1FF,
               9'h000, 9'h001, 9'h002, 9'h003};
        check_reads("t2_rd", ea);

        // backpressure keeps the descriptor stable
        set_desc(9'h040, 32'hCAFE_0001, 32'hBEEF_0002, 1'b1, 7'h7F,
                 16'hFFFF, 9'h050, 1'b1);
        set_desc(9'h050, 32'h0, 32'h0, 1'b0, 7'h00, 16'h0, 9'h000, 1'b0);
        start_chain(9'h040);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("t3_hold_%0d", i),
                {desc_valid, desc_src, desc_dst, desc_len, desc_ctrl},
                {1'b1, 32'hCAFE_0001, 32'hBEEF_0002, 16'hFFFF, 7'h7F});
        end
        accept();
        complete(8'h02, 16'h0010);
        wait_end(kind);
        chk("t3_end", kind, 1);
        tick();

        // self-looping descriptor against MAX_CHAIN=3
        h0 = hs_cnt;
        w0 = wr_cnt;
        for (int k = 0; k < N_T4; k++) begin
            set_desc(9'h060, 32'h0600_0000, 32'h0700_0000, 1'b1, 7'h03,
                     16'h0008, 9'h060, 1'b1);
        end
        start_chain(9'h060);
        for (int k = 0; k < N_T4; k++) begin
            wait_valid(lat);
            if (k == 0) chk("t4_latency", lat, 6);
            else chk($sformatf("t4_cmpl_lat_%0d", k), lat, CMPL_LAT);
            accept();
            complete(8'h00, 16'h0008);
        end
        wait_end(kind);
        chk("t4_end", kind, T4_KIND);
        tick();
        chk("t4_pulse_gone", {done, err, busy}, 3'b000);
        chk("t4_handshakes", hs_cnt - h0, N_T4);
`ifdef DESC_FETCH_WRITEBACK_EN
        chk("t4_writes", wr_cnt - w0, 1);
`else
        chk("t4_writes", wr_cnt - w0, 0);
`endif

        // abort while presenting, then a fresh start
        set_desc(9'h080, 32'h0800_0000, 32'h0900_0000, 1'b1, 7'h01,
                 16'h0020, 9'h090, 1'b0);
        set_desc(9'h090, 32'h0, 32'h0, 1'b0, 7'h00, 16'h0, 9'h000, 1'b0);
        w0 = wr_cnt;
        start_chain(9'h080);
        wait_valid(lat);
        abort = 1'b1;
        #1;
        chk("t5_valid_drop", desc_valid, 0);
        tick();
        abort = 1'b0;
        chk("t5_done", {done, busy}, 2'b11);
        tick();
        chk("t5_idle", {done, busy}, 2'b00);
        chk("t5_no_write", wr_cnt, w0);
        sb_q.push_back({32'h0800_0000, 32'h0900_0000, 16'h0020, 7'h01});
        start_chain(9'h080);
        wait_valid(lat);
        chk("t5_restart_lat", lat, 6);
        accept();
        complete(8'h05, 16'h0020);
        wait_end(kind);
        chk("t5_restart_end", kind, 1);
        tick();

        // reset while waiting for completion
        set_desc(9'h0A0, 32'h0A00_0000, 32'h0B00_0000, 1'b1, 7'h44,
                 16'h0080, 9'h0B0, 1'b1);
        set_desc(9'h0B0, 32'h0, 32'h0, 1'b0, 7'h00, 16'h0, 9'h000, 1'b0);
        start_chain(9'h0A0);
        wait_valid(lat);
        accept();
        tick();
        reset = 1'b1;
        #1;
        check_reset("t6_reset_outs");
        tick();
        reset = 1'b0;
        h0 = hs_cnt;
        w0 = wr_cnt;
        rd_q.delete();
        complete(8'h07, 16'h0080);
        repeat (12) tick();
        check_reset("t6_idle_outs");
        chk("t6_no_reads", rd_q.size(), 0);
        chk("t6_no_writes", wr_cnt, w0);
        chk("t6_no_hs", hs_cnt, h0);

        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
